// File: rtl/t09_edge_event_unit.sv
// Multi-channel edge-event unit: per-channel edge pulse, sticky pending flag and saturating counter.
// Define T09_EDGE_SYNC_EN to insert a two-flop input synchroniser per channel (latency 3 edges).
module t09_edge_event_unit #(
   parameter int NCH   = 2,
   parameter int CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       sig_i,
   input  logic [2*NCH-1:0]     edgeMode,
   input  logic [NCH-1:0]       clrPend,
   input  logic                 clrCnt,
   output logic [NCH-1:0]       pulse,
   output logic [NCH-1:0]       pending,
   output logic [NCH*CNT_W-1:0] count,
   output logic                 anyPending
);

   logic [NCH-1:0]   cur_q, cur_d;
   logic [NCH-1:0]   prev_q, prev_d;
   logic [NCH-1:0]   pending_q, pending_d;
   logic [CNT_W-1:0] count_q [NCH];
   logic [CNT_W-1:0] count_d [NCH];
   logic [NCH-1:0]   evt;

`ifdef T09_EDGE_SYNC_EN
   logic [NCH-1:0] meta_q, meta_d;
   logic [NCH-1:0] sync_q, sync_d;

   always_comb begin
      meta_d = sig_i;
      sync_d = meta_q;
      cur_d  = sync_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end
`else
   always_comb begin
      cur_d = sig_i;
   end
`endif

   // Mode is applied combinationally, so a mode change affects detection in the same cycle.
   always_comb begin
      prev_d    = cur_q;
      evt       = '0;
      pending_d = pending_q;
      count_d   = count_q;
      for (int unsigned i = 0; i < NCH; i++) begin
         evt[i] = (edgeMode[2*i]   &  cur_q[i] & ~prev_q[i])
                | (edgeMode[2*i+1] & ~cur_q[i] &  prev_q[i]);
         pending_d[i] = evt[i] | (pending_q[i] & ~clrPend[i]);
         if (clrCnt) begin
            count_d[i] = evt[i] ? CNT_W'(1) : '0;
         end else if (evt[i] && (count_q[i] != '1)) begin
            count_d[i] = count_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_q     <= '0;
         prev_q    <= '0;
         pending_q <= '0;
         for (int unsigned i = 0; i < NCH; i++) begin
            count_q[i] <= '0;
         end
      end else begin
         cur_q     <= cur_d;
         prev_q    <= prev_d;
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

   always_comb begin
      pulse      = evt;
      pending    = pending_q;
      anyPending = |pending_q;
      count      = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         count[i*CNT_W +: CNT_W] = count_q[i];
      end
   end

endmodule

// File: tb/tb_t09_edge_event_unit.sv
// Directed self-checking bench for t09_edge_event_unit (NCH=2, CNT_W=3).
module tb_t09_edge_event_unit;

   localparam int NCH   = 2;
   localparam int CNT_W = 3;
`ifdef T09_EDGE_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic                 clk = 1'b0;
   logic                 rst = 1'b0;
   logic [NCH-1:0]       sig_i = '0;
   logic [2*NCH-1:0]     edgeMode = 4'b0101;
   logic [NCH-1:0]       clrPend = '0;
   logic                 clrCnt = 1'b0;
   logic [NCH-1:0]       pulse;
   logic [NCH-1:0]       pending;
   logic [NCH*CNT_W-1:0] count;
   logic                 anyPending;

   int nvec = 0;
   int nerr = 0;
   int pcnt [NCH];

   t09_edge_event_unit #(.NCH(NCH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .sig_i      (sig_i),
      .edgeMode   (edgeMode),
      .clrPend    (clrPend),
      .clrCnt     (clrCnt),
      .pulse      (pulse),
      .pending    (pending),
      .count      (count),
      .anyPending (anyPending)
   );

   always #5 clk = ~clk;

   function automatic logic [CNT_W-1:0] cnt(input int ch);
      return count[ch*CNT_W +: CNT_W];
   endfunction

   // Advance one clock, then tally any pulses visible in the new cycle.
   task automatic tick();
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
         if (pulse[c] === 1'b1) pcnt[c]++;
      end
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic clr_pcnt();
      for (int c = 0; c < NCH; c++) pcnt[c] = 0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      clr_pcnt();
      // Reset with inputs high
      sig_i = 2'b11;
      #1 rst = 1'b1;
      ticks(2);
      chk("rst_pulse", 32'(pulse), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_anypend", 32'(anyPending), 32'd0);

      // Release with inputs low: quiet for 10 cycles
      sig_i = 2'b00;
      rst   = 1'b0;
      clr_pcnt();
      ticks(10);
      chk("quiet_p0", 32'(pcnt[0]), 32'd0);
      chk("quiet_p1", 32'(pcnt[1]), 32'd0);
      chk("quiet_count", 32'(count), 32'd0);

      // Rising mode, channel 1 0->1 held 5 cycles
      edgeMode = 4'b0101;
      sig_i    = 2'b10;
      clr_pcnt();
      ticks(5);
      chk("rise_p1", 32'(pcnt[1]), 32'd1);
      chk("rise_p0", 32'(pcnt[0]), 32'd0);
      chk("rise_pending", 32'(pending), 32'b10);
      chk("rise_cnt1", 32'(cnt(1)), 32'd1);
      chk("rise_cnt0", 32'(cnt(0)), 32'd0);
      chk("rise_anypend", 32'(anyPending), 32'd1);

      clrPend = 2'b11;
      tick();
      clrPend = 2'b00;
      chk("clr_pending", 32'(pending), 32'd0);
      chk("clr_anypend", 32'(anyPending), 32'd0);

      // Both-edge on ch0, ch1 off
      edgeMode = 4'b0011;
      clrCnt   = 1'b1;
      tick();
      clrCnt   = 1'b0;
      chk("clrcnt_all", 32'(count), 32'd0);
      clr_pcnt();
      for (int k = 0; k < 3; k++) begin
         sig_i[0] = 1'b1; tick();
         sig_i[0] = 1'b0; tick();
      end
      ticks(4);
      chk("both_p0", 32'(pcnt[0]), 32'd6);
      chk("both_p1", 32'(pcnt[1]), 32'd0);
      chk("both_cnt0", 32'(cnt(0)), 32'd6);
      chk("both_pending", 32'(pending), 32'b01);

      // Falling-only on ch0
      edgeMode = 4'b0010;
      clrCnt   = 1'b1;
      tick();
      clrCnt   = 1'b0;
      clr_pcnt();
      for (int k = 0; k < 3; k++) begin
         sig_i[0] = 1'b1; tick();
         sig_i[0] = 1'b0; tick();
      end
      ticks(4);
      chk("fall_p0", 32'(pcnt[0]), 32'd3);
      chk("fall_cnt0", 32'(cnt(0)), 32'd3);

      // Pending clear priority: set wins over simultaneous clear
      edgeMode = 4'b0001;
      clrPend  = 2'b01;
      tick();
      clrPend  = 2'b00;
      chk("prio_pre_pending", 32'(pending), 32'd0);
      sig_i[0] = 1'b1;
      ticks(LAT);
      chk("prio_pulse", 32'(pulse), 32'b01);
      clrPend = 2'b01;
      tick();
      chk("prio_set_wins", 32'(pending), 32'b01);
      tick();
      clrPend = 2'b00;
      chk("prio_cleared", 32'(pending), 32'd0);
      chk("prio_anypend", 32'(anyPending), 32'd0);

      // Saturation at 7 with 9 rising events
      clrCnt = 1'b1;
      tick();
      clrCnt = 1'b0;
      chk("sat_start", 32'(cnt(0)), 32'd0);
      clr_pcnt();
      for (int k = 0; k < 9; k++) begin
         sig_i[0] = 1'b0; tick();
         sig_i[0] = 1'b1; tick();
      end
      ticks(LAT + 1);
      chk("sat_pulses", 32'(pcnt[0]), 32'd9);
      chk("sat_cnt0", 32'(cnt(0)), 32'd7);

      // clrCnt coincident with an event loads 1
      sig_i[0] = 1'b0;
      ticks(LAT + 1);
      chk("sat_hold", 32'(cnt(0)), 32'd7);
      sig_i[0] = 1'b1;
      ticks(LAT);
      chk("clrev_pulse", 32'(pulse[0]), 32'd1);
      clrCnt = 1'b1;
      tick();
      clrCnt = 1'b0;
      chk("clrev_cnt0", 32'(cnt(0)), 32'd1);

      // Mode 00: nothing happens
      edgeMode = 4'b0000;
      clrPend  = 2'b11;
      clrCnt   = 1'b1;
      tick();
      clrPend  = 2'b00;
      clrCnt   = 1'b0;
      clr_pcnt();
      for (int k = 0; k < 3; k++) begin
         sig_i = 2'b00; tick();
         sig_i = 2'b11; tick();
      end
      ticks(4);
      chk("off_p0", 32'(pcnt[0]), 32'd0);
      chk("off_p1", 32'(pcnt[1]), 32'd0);
      chk("off_pending", 32'(pending), 32'd0);
      chk("off_count", 32'(count), 32'd0);

      // Asynchronous reset mid-pulse, then inputs held high across release
      edgeMode = 4'b0101;
      sig_i    = 2'b00;
      ticks(LAT + 1);
      sig_i = 2'b11;
      ticks(LAT);
      chk("arst_pre_pulse", 32'(pulse), 32'b11);
      #1 rst = 1'b1;
      #1;
      chk("arst_pulse", 32'(pulse), 32'd0);
      chk("arst_pending", 32'(pending), 32'd0);
      chk("arst_count", 32'(count), 32'd0);
      ticks(2);
      rst = 1'b0;
      clr_pcnt();
      ticks(5);
      chk("held_p0", 32'(pcnt[0]), 32'd1);
      chk("held_p1", 32'(pcnt[1]), 32'd1);
      chk("held_pending", 32'(pending), 32'b11);
      chk("held_count", 32'(count), 32'b001001);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
